sprite_blitter: RTL and testbench

- Copies one sprite from a sprite ROM into the RGB565 frame buffer at a requested screen position.
- Walks the sprite raster in row-major order and drives the ROM's pixel index. Takes the ROM's combinational 16-bit colour back.
- Drops the transparent key colour and off-screen pixels. Writes everything else to the frame-buffer write port under a ready handshake.
- Sits between the game/scene controller, which issues draw commands, and the frame-buffer RAM.

---
 rtl/sprite_blitter_if.sv | 27 ++
 rtl/sprite_blitter.sv | 96 +++++++++
 tb/tb_sprite_blitter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Bundles the sprite blitter's command, sprite ROM and frame-buffer write signals.
// The master side is the blitter. The slave side is the scene controller, ROM and frame buffer.
interface sprite_blitter_if;
    logic        start;
    logic [8:0]  pos_x;
    logic [7:0]  pos_y;
    logic [5:0]  sprite_w;
    logic [5:0]  sprite_h;
    logic [16:0] pixel;
    logic [15:0] color;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, pos_x, pos_y, sprite_w, sprite_h, color, fb_ready,
        output pixel, fb_addr, fb_data, fb_we, busy, done
    );

    modport slave (
        output start, pos_x, pos_y, sprite_w, sprite_h, color, fb_ready,
        input  pixel, fb_addr, fb_data, fb_we, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Copies one sprite from ROM into an RGB565 frame buffer at a screen position.
// Transparent-key pixels and off-screen pixels are skipped. Each pixel uses one FETCH cycle and one WRITE cycle.
module sprite_blitter #(
    parameter int          SCREEN_W    = 320,
    parameter int          SCREEN_H    = 240,
    parameter logic [15:0] TRANSPARENT = 16'hFFFF
) (
    input logic              clk,
    input logic              reset,
    sprite_blitter_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    localparam logic [9:0] SW = 10'(SCREEN_W);
    localparam logic [8:0] SH = 9'(SCREEN_H);

    state_t      state, state_nx;
    logic [8:0]  px_q;
    logic [7:0]  py_q;
    logic [5:0]  w_q, h_q;
    logic [5:0]  row, col;
    logic [16:0] idx;
    logic [15:0] col_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic        wr, adv, row_end, last;

    // The target coordinates are one bit wider than the screen bounds, so clipping never sees a wrapped value.
    assign wr      = (col_q != TRANSPARENT) && (x_q < SW) && (y_q < SH);
    assign adv     = (state == WRITE) && (!wr || bus.fb_ready);
    assign row_end = (col == w_q - 6'd1);
    assign last    = row_end && (row == h_q - 6'd1);

    assign bus.pixel   = idx;
    assign bus.fb_we   = (state == WRITE) && wr;
    assign bus.fb_addr = 17'(y_q) * 17'(SCREEN_W) + 17'(x_q);
    assign bus.fb_data = col_q;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start)
                       state_nx = (bus.sprite_w == 6'd0 || bus.sprite_h == 6'd0) ? DONE : FETCH;
            FETCH: state_nx = WRITE;
            WRITE: if (adv) state_nx = last ? DONE : FETCH;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q  <= '0;
            py_q  <= '0;
            w_q   <= '0;
            h_q   <= '0;
            row   <= '0;
            col   <= '0;
            idx   <= '0;
            col_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                px_q <= bus.pos_x;
                py_q <= bus.pos_y;
                w_q  <= bus.sprite_w;
                h_q  <= bus.sprite_h;
                row  <= '0;
                col  <= '0;
                idx  <= '0;
            end
            if (state == FETCH) begin
                col_q <= bus.color;
                x_q   <= {1'b0, px_q} + 10'(col);
                y_q   <= {1'b0, py_q} + 9'(row);
            end
            if (adv) begin
                idx <= idx + 17'd1;
                if (row_end) begin
                    col <= '0;
                    row <= row + 6'd1;
                end else begin
                    col <= col + 6'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a queue holds the expected frame-buffer writes,
// and a negedge monitor pops one entry for every accepted write.
module tb_sprite_blitter;
    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
        logic [16:0] pix;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rom [16];
    exp_t        sbq [$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          start_cyc = 0;

    sprite_blitter_if ifc ();

    sprite_blitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ifc.color = rom[ifc.pixel[3:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [16:0] a, input logic [15:0] d, input logic [16:0] p);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.pix  = p;
        sbq.push_back(e);
    endtask

    task automatic fill_rom(input logic [15:0] c);
        for (int i = 0; i < 16; i++) rom[i] = c;
    endtask

    // Monitor: pops the scoreboard on every accepted write and counts done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ifc.fb_we && ifc.fb_ready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0d data %0h", ifc.fb_addr, ifc.fb_data);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", 32'(ifc.fb_addr), 32'(e.addr));
                chk("wr_data", 32'(ifc.fb_data), 32'(e.data));
                chk("wr_pixel", 32'(ifc.pixel), 32'(e.pix));
            end
        end
        if (!reset && ifc.done) done_cnt++;
    end

    task automatic start_draw(input logic [8:0] x, input logic [7:0] y,
                              input logic [5:0] w, input logic [5:0] h);
        ifc.start    = 1'b1;
        ifc.pos_x    = x;
        ifc.pos_y    = y;
        ifc.sprite_w = w;
        ifc.sprite_h = h;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lo, input int hi);
        bit got = 1'b0;
        int lat;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (ifc.done) got = 1'b1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s_timeout: done not seen, required within %0d cycles", name, hi);
        end else begin
            lat = cyc - start_cyc + 1;
            if (lat < lo || lat > hi) begin
                fails++;
                $display("FAIL %s_latency: got %0d required %0d..%0d", name, lat, lo, hi);
            end
            @(negedge clk);
            chk({name, "_done_pulse"}, 32'(ifc.done), 32'd0);
            chk({name, "_busy_fall"}, 32'(ifc.busy), 32'd0);
        end
        chk({name, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int dc0;
        reset        = 1'b1;
        ifc.start    = 1'b0;
        ifc.pos_x    = '0;
        ifc.pos_y    = '0;
        ifc.sprite_w = '0;
        ifc.sprite_h = '0;
        ifc.fb_ready = 1'b1;
        fill_rom(16'h1234);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_fb_we", 32'(ifc.fb_we), 32'd0);
        chk("rst_pixel", 32'(ifc.pixel), 32'd0);
        chk("rst_fb_addr", 32'(ifc.fb_addr), 32'd0);
        chk("rst_fb_data", 32'(ifc.fb_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: opaque 2x2 at the origin
        push(17'd0, 16'h1234, 17'd0);
        push(17'd1, 16'h1234, 17'd1);
        push(17'd320, 16'h1234, 17'd2);
        push(17'd321, 16'h1234, 17'd3);
        start_draw(9'd0, 8'd0, 6'd2, 6'd2);
        chk("t1_busy", 32'(ifc.busy), 32'd1);
        wait_done("t1", 9, 9);

        // 2: pixel 1 carries the transparent key
        rom[1] = 16'hFFFF;
        push(17'd0, 16'h1234, 17'd0);
        push(17'd320, 16'h1234, 17'd2);
        push(17'd321, 16'h1234, 17'd3);
        start_draw(9'd0, 8'd0, 6'd2, 6'd2);
        wait_done("t2", 9, 9);
        fill_rom(16'h1234);

        // 3: backpressure on the first write
        ifc.fb_ready = 1'b0;
        push(17'd0, 16'h1234, 17'd0);
        push(17'd1, 16'h1234, 17'd1);
        push(17'd320, 16'h1234, 17'd2);
        push(17'd321, 16'h1234, 17'd3);
        start_draw(9'd0, 8'd0, 6'd2, 6'd2);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_we", 32'(ifc.fb_we), 32'd1);
            chk("t3_hold_addr", 32'(ifc.fb_addr), 32'd0);
            chk("t3_hold_data", 32'(ifc.fb_data), 32'h1234);
            @(posedge clk);
        end
        #1 ifc.fb_ready = 1'b1;
        wait_done("t3", 12, 12);

        // 4: bottom-right corner, only the top-left pixel lands on screen
        push(17'd76799, 16'h1234, 17'd0);
        start_draw(9'd319, 8'd239, 6'd2, 6'd2);
        wait_done("t4", 9, 9);

        // 5: reset during the FETCH of pixel 2 of a 3x3 draw
        for (int i = 0; i < 16; i++) rom[i] = 16'h0100 + 16'(i);
        push(17'd1610, 16'h0100, 17'd0);
        push(17'd1611, 16'h0101, 17'd1);
        dc0 = done_cnt;
        start_draw(9'd10, 8'd5, 6'd3, 6'd3);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_fb_we", 32'(ifc.fb_we), 32'd0);
        chk("t5_rst_busy", 32'(ifc.busy), 32'd0);
        chk("t5_rst_sb", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("t5_idle_busy", 32'(ifc.busy), 32'd0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                push(17'((5 + r) * 320 + 10 + c), 16'h0100 + 16'(r * 3 + c), 17'(r * 3 + c));
        start_draw(9'd10, 8'd5, 6'd3, 6'd3);
        wait_done("t5", 19, 19);

        // 6: a start while busy is ignored; then a zero-width sprite
        fill_rom(16'h1234);
        push(17'd0, 16'h1234, 17'd0);
        push(17'd1, 16'h1234, 17'd1);
        push(17'd320, 16'h1234, 17'd2);
        push(17'd321, 16'h1234, 17'd3);
        dc0 = done_cnt;
        start_draw(9'd0, 8'd0, 6'd2, 6'd2);
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        ifc.pos_x = 9'd100;
        ifc.pos_y = 8'd100;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        wait_done("t6", 9, 9);
        repeat (20) @(negedge clk);
        chk("t6_one_done", 32'(done_cnt - dc0), 32'd1);

        dc0 = done_cnt;
        start_draw(9'd5, 8'd5, 6'd0, 6'd2);
        wait_done("t6z", 1, 2);
        repeat (5) @(negedge clk);
        chk("t6z_one_done", 32'(done_cnt - dc0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
